// File: rtl/rf_sequencer.sv
// rf_sequencer: accepts register-to-register commands and sequences read, execute, write and response on an 8x16 2R1W register file.
// Optional RF_SEQ_FAST_LDI_EN: LDI skips READ/EXEC and goes straight from IDLE to WRITE.
module rf_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_d_out_a,
    input  logic [DATA_W-1:0] rf_d_out_b,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_RD  = 3'd7;

    state_t              state_q, state_d;
    logic                init_q, init_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   src_a_q, src_a_d;
    logic [ADDR_W-1:0]   src_b_q, src_b_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   d_in_q, d_in_d;
    logic [DATA_W-1:0]   alu;
    logic                accept;
    logic                fast_ldi;

`ifdef RF_SEQ_FAST_LDI_EN
    assign fast_ldi = (cmd_op == OP_LDI);
`else
    assign fast_ldi = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast_ldi ? WRITE : READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = (op_q == OP_RD) ? RESP : WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // init_q holds cmd_ready low until the first edge after reset release
    always_comb begin
        cmd_ready = init_q && (state_q == IDLE);
        rf_wr     = (state_q == WRITE);
        rsp_valid = (state_q == RESP);
        rsp_zero  = (state_q == RESP) && (result_q == '0);
    end

    assign rf_rd_addr_a = src_a_q;
    assign rf_rd_addr_b = src_b_q;
    assign rf_wr_addr   = wr_addr_q;
    assign rf_d_in      = d_in_q;
    assign rsp_data     = result_q;

    always_comb begin
        alu = opa_q;
        case (op_q)
            OP_ADD:  alu = opa_q + opb_q;
            OP_SUB:  alu = opa_q - opb_q;
            OP_AND:  alu = opa_q & opb_q;
            OP_OR:   alu = opa_q | opb_q;
            OP_XOR:  alu = opa_q ^ opb_q;
            OP_MOV:  alu = opa_q;
            OP_LDI:  alu = imm_q;
            default: alu = opa_q;
        endcase
    end

    always_comb begin
        init_d    = 1'b1;
        op_d      = op_q;
        dst_d     = dst_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        imm_d     = imm_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        wr_addr_d = wr_addr_q;
        d_in_d    = d_in_q;
        if (accept) begin
            op_d    = cmd_op;
            dst_d   = cmd_dst;
            src_a_d = cmd_src_a;
            src_b_d = cmd_src_b;
            imm_d   = cmd_imm;
        end
        if (accept && fast_ldi) begin
            result_d  = cmd_imm;
            wr_addr_d = cmd_dst;
            d_in_d    = cmd_imm;
        end
        if (state_q == READ) begin
            opa_d = rf_d_out_a;
            opb_d = rf_d_out_b;
        end
        // write port registers only change on entry to WRITE so they hold between writes
        if (state_q == EXEC) begin
            result_d = alu;
            if (op_q != OP_RD) begin
                wr_addr_d = dst_q;
                d_in_d    = alu;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q    <= 1'b0;
            op_q      <= '0;
            dst_q     <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            wr_addr_q <= '0;
            d_in_q    <= '0;
        end else begin
            init_q    <= init_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            imm_q     <= imm_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            wr_addr_q <= wr_addr_d;
            d_in_q    <= d_in_d;
        end
    end
endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: drives random and directed commands into rf_sequencer with a behavioural register file and checks against a reference model.
module tb_rf_sequencer;
    localparam int DW = 16;
    localparam int AW = 3;
`ifdef RF_SEQ_FAST_LDI_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_dst, cmd_src_a, cmd_src_b;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
    logic [DW-1:0] rf_d_out_a, rf_d_out_b, rf_d_in;
    logic          rf_wr, rsp_valid, rsp_ready, rsp_zero;
    logic [DW-1:0] rsp_data;

    logic [DW-1:0] rf [8];
    logic [DW-1:0] ref_rf [8];
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rf_d_out_a = rf[rf_rd_addr_a];
    assign rf_d_out_b = rf[rf_rd_addr_b];
    always @(posedge clk) if (rf_wr) rf[rf_wr_addr] <= rf_d_in;

    rf_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b),
        .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] imm);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd6:    return imm;
            default: return a;
        endcase
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Issue one command at a negedge and follow it cycle by cycle to completion.
    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                           input logic [AW-1:0] sb, input logic [DW-1:0] imm, input int hold);
        logic [DW-1:0] exp;
        int wc, rc;
        exp = model(op, ref_rf[sa], ref_rf[sb], imm);
        wc = (op == 3'd7) ? -1 : ((FAST && op == 3'd6) ? 1 : 3);
        rc = (op == 3'd7) ? 3 : ((FAST && op == 3'd6) ? 2 : 4);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= rc; k++) begin
            check("rf_wr_timing", {31'd0, rf_wr}, {31'd0, k == wc});
            if (k == wc) begin
                check("rf_wr_addr", {29'd0, rf_wr_addr}, {29'd0, dst});
                check("rf_d_in", {16'd0, rf_d_in}, {16'd0, exp});
            end
            check("rsp_valid_timing", {31'd0, rsp_valid}, {31'd0, k == rc});
            check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (k < rc) @(negedge clk);
        end
        check("rsp_data", {16'd0, rsp_data}, {16'd0, exp});
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, exp == '0});
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_op = 3'($urandom_range(0, 7));
            cmd_dst = 3'($urandom_range(0, 7));
            cmd_imm = 16'($urandom);
            check("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            check("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            check("rsp_data_hold", {16'd0, rsp_data}, {16'd0, exp});
            check("rf_wr_in_resp", {31'd0, rf_wr}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        if (op != 3'd7) ref_rf[dst] = exp;
    endtask

    initial begin
        int k;
        logic [DW-1:0] v;
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
        check("rst_rd_addr_a", {29'd0, rf_rd_addr_a}, 32'd0);
        check("rst_rd_addr_b", {29'd0, rf_rd_addr_b}, 32'd0);
        check("rst_wr_addr", {29'd0, rf_wr_addr}, 32'd0);
        check("rst_d_in", {16'd0, rf_d_in}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        for (int r = 0; r < 8; r++) run_cmd(3'd6, 3'(r), 3'd0, 3'd0, 16'($urandom), 0);

        run_cmd(3'd6, 3'd3, 3'd0, 3'd0, 16'h1234, 0);
        run_cmd(3'd6, 3'd5, 3'd0, 3'd0, 16'h0FFF, 0);
        run_cmd(3'd0, 3'd1, 3'd3, 3'd5, 16'h0000, 0);
        check("add_result_r1", {16'd0, rf[1]}, 32'h2233);
        run_cmd(3'd1, 3'd2, 3'd5, 3'd3, 16'h0000, 1);
        check("sub_result_r2", {16'd0, rf[2]}, 32'hFDCB);
        run_cmd(3'd6, 3'd4, 3'd0, 3'd0, 16'hABCD, 0);
        run_cmd(3'd4, 3'd4, 3'd4, 3'd4, 16'h0000, 0);
        check("xor_result_r4", {16'd0, rf[4]}, 32'h0000);
        run_cmd(3'd7, 3'd0, 3'd3, 3'd0, 16'h0000, 3);
        run_cmd(3'd6, 3'd7, 3'd0, 3'd0, 16'h00FF, 2);

        for (int i = 0; i < 60; i++)
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 3));

        // Abort an LDI r6 during its write cycle; r6 must keep its old value.
        wait_ready();
        v = ref_rf[6] ^ 16'h5A5A;
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_dst = 3'd6; cmd_src_a = 3'd2; cmd_src_b = 3'd1; cmd_imm = v;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rf_wr && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("abort_wr_seen", {31'd0, rf_wr}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_rf_wr", {31'd0, rf_wr}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rd_addr_a", {29'd0, rf_rd_addr_a}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("abort_rsp_after", {31'd0, rsp_valid}, 32'd0);
        check("abort_r6_kept", {16'd0, rf[6]}, {16'd0, ref_rf[6]});
        run_cmd(3'd7, 3'd0, 3'd6, 3'd0, 16'h0000, 0);
        run_cmd(3'd5, 3'd0, 3'd6, 3'd3, 16'h0000, 0);

        for (int r = 0; r < 8; r++) check("final_rf", {16'd0, rf[r]}, {16'd0, ref_rf[r]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_sequencer.md
Name: rf_sequencer

Overview:
- Initiator-side controller for the 8x16 two-read/one-write register file.
- Accepts register-to-register commands over a valid/ready handshake, then runs a fixed sequence:
  - drives both read addresses and captures the operands;
  - computes the result;
  - drives the write port;
  - returns the result on a response handshake.
- Sits between the control path and the register file. It is the only master of the register file's wr/wr_addr/d_in and rd_addr_a/rd_addr_b inputs.

Parameters:
DATA_W, 16, register/data width (must match register file)
ADDR_W, 3, register address width (8 registers)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 RD
cmd_dst  input  ADDR_W  destination register
cmd_src_a  input  ADDR_W  source A register
cmd_src_b  input  ADDR_W  source B register
cmd_imm  input  DATA_W  immediate for LDI
rf_rd_addr_a  output  ADDR_W  to register file read port A
rf_rd_addr_b  output  ADDR_W  to register file read port B
rf_d_out_a  input  DATA_W  from register file port A (combinational read)
rf_d_out_b  input  DATA_W  from register file port B
rf_wr  output  1  register file write enable
rf_wr_addr  output  ADDR_W  register file write address
rf_d_in  output  DATA_W  register file write data
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  DATA_W  result value
rsp_zero  output  1  rsp_data == 0

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0 immediately, including cmd_ready, rf_wr, rf_* addresses/data, rsp_*.
  - State goes to IDLE; the latched command and operands clear to 0.
  - cmd_ready rises in the first cycle after reset deasserts.
- States: IDLE -> READ -> EXEC -> WRITE -> RESP -> IDLE. RD skips WRITE (EXEC -> RESP).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at a rising edge, latch op/dst/src_a/src_b/imm and go to READ.
  - cmd_ready=0 in every other state. cmd_valid outside IDLE is ignored and not buffered.
- rf_rd_addr_a/b are driven from the latched src_a/src_b at all times; they are 0 after reset.
- READ: capture rf_d_out_a/rf_d_out_b into operand registers at the end of the cycle; go to EXEC.
- EXEC: compute result into the result register.
  - ADD: A+B. SUB: A-B. Both are modulo 2^DATA_W; carry/borrow is discarded.
  - AND, OR, XOR: bitwise on A and B.
  - MOV: A. LDI: imm. RD: A.
  - Go to WRITE (RD goes to RESP).
- WRITE: rf_wr=1 for exactly one cycle, with rf_wr_addr=dst and rf_d_in=result; go to RESP.
  - rf_wr is 0 in all other states; rf_wr_addr/rf_d_in hold their last values.
- RESP:
  - rsp_valid=1, rsp_data=result, rsp_zero=(result==0).
  - Hold until rsp_ready=1 at a rising edge, then go to IDLE.
  - rsp_data is stable while rsp_valid=1.
- Latency: accept edge at cycle 0 -> READ c1, EXEC c2, WRITE c3, rsp_valid from c4. With rsp_ready held high, one command every 5 cycles.
- src==dst is legal: operands are captured before the write, so the old value is used.
- A command accepted after RESP observes all earlier writes, because the register file write has completed by then.
- Reset mid-operation (any state): the command is aborted and no write is issued after reset asserts. A write already clocked in stays in the register file.

Optional Feature:
- Macro RF_SEQ_FAST_LDI_EN.
- Defined: LDI goes IDLE -> WRITE directly (result=imm loaded at accept), so rf_wr is in c1 and rsp_valid is from c2. All other opcodes are unchanged.
- Undefined: LDI takes the full READ/EXEC path, with rf_wr in c3.

Test Plan:
- Reset: assert reset mid-WRITE -> rf_wr drops to 0 without a clock edge; after release cmd_ready=1 next cycle, rsp_valid=0.
- LDI r3=0x1234, then LDI r5=0x0FFF, then ADD r1=r3+r5:
  - rf_wr at c3 with addr=1, data=0x2233;
  - rsp_data=0x2233, rsp_zero=0.
- SUB r2=r5-r3 with r3=0x1234, r5=0x0FFF -> result 0xFDCB (wrap), written to r2.
- XOR r4=r4^r4 with r4=0xABCD -> rf_d_in=0x0000, rsp_zero=1; src==dst uses the old value.
- RD r3 -> rsp_data=0x1234 and no rf_wr pulse. Hold rsp_ready=0 for 3 cycles -> rsp_valid stays 1 with stable data; cmd_valid during that window is not accepted.
- With RF_SEQ_FAST_LDI_EN: LDI r7=0x00FF -> rf_wr at c1, rsp_valid at c2. Without it -> rf_wr at c3, rsp_valid at c4.
